// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
//   sqi_data_t   : 4-bit nibble as produced by the execute unit's ALU.
//   uart_byte_t  : one UART payload byte.
//   utx_state_t  : UART TX serialiser states.
//   UART_START_BIT / UART_STOP_BIT : line levels for the framing bits.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;
  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    UTX_IDLE,
    UTX_START,
    UTX_DATA,
    UTX_STOP
  } utx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/idli_utx_fifo_m.sv
// Synchronous byte FIFO feeding the UART TX serialiser.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, empties the FIFO
//   push_i  : write data_i this cycle (dropped if full and no pop)
//   data_i  : byte to write
//   pop_i   : consume the head entry this cycle (ignored when empty)
//   data_o  : head entry (valid whenever empty_o is low)
//   empty_o : no entries stored
//   rdy_o   : registered "not full"
//   drop_o  : pulses when a push is discarded because the FIFO is full
module idli_utx_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  uart_byte_t data_i,
  input  logic       pop_i,
  output uart_byte_t data_o,
  output logic       empty_o,
  output logic       rdy_o,
  output logic       drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  uart_byte_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rdy_q, rdy_d;

  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the write when the serialiser is draining it.
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);
  assign drop_o  = push_i & full & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
    rdy_d = (count_d != FULL_COUNT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Head entry is read combinationally so the serialiser can load it on
  // the same edge it pops.
  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty;
  assign rdy_o   = rdy_q;

endmodule

// File: rtl/idli_uart_tx_m.sv
// UART transmitter attached to the execute unit's nibble stream.
// Nibbles arrive low half first and are paired into bytes, queued in a
// small FIFO and sent as 8N1 frames.
//   i_utx_gck  : core clock
//   i_utx_rst  : synchronous active-high reset
//   i_utx_vld  : i_utx_data carries a nibble this cycle
//   i_utx_data : nibble from the ALU output
//   o_utx_rdy  : FIFO not full (status only)
//   o_utx_ovf  : sticky, a byte was dropped on a full FIFO
//   o_utx_idle : nothing queued, nothing in flight, no half byte pending
//   o_utx_tx   : serial line, idle high
module idli_uart_tx_m
  import idli_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      i_utx_gck,
  input  logic      i_utx_rst,
  input  logic      i_utx_vld,
  input  sqi_data_t i_utx_data,
  output logic      o_utx_rdy,
  output logic      o_utx_ovf,
  output logic      o_utx_idle,
  output logic      o_utx_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Nibble assembly
  logic      phase_q, phase_d;
  sqi_data_t nib_lo_q, nib_lo_d;

  logic       fifo_push;
  uart_byte_t push_byte;

  always_comb begin
    phase_d  = phase_q;
    nib_lo_d = nib_lo_q;
    if (i_utx_vld) begin
      phase_d = ~phase_q;
      if (!phase_q) nib_lo_d = i_utx_data;
    end
  end

  assign fifo_push = i_utx_vld & phase_q;
  assign push_byte = {i_utx_data, nib_lo_q};

  // Byte FIFO
  logic       fifo_pop;
  uart_byte_t fifo_rdata;
  logic       fifo_empty;
  logic       fifo_rdy;
  logic       fifo_drop;

  idli_utx_fifo_m #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_utx_gck),
    .rst_i   (i_utx_rst),
    .push_i  (fifo_push),
    .data_i  (push_byte),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .rdy_o   (fifo_rdy),
    .drop_o  (fifo_drop)
  );

  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | fifo_drop;

  // Serialiser
  utx_state_t        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  uart_byte_t        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = UART_STOP_BIT;

    // The line level is a registered copy of the current state's bit, so
    // o_utx_tx trails the state register by one cycle; every bit period
    // keeps its full length and frames remain contiguous.
    case (state_q)
      UTX_IDLE: begin
        tx_d = UART_STOP_BIT;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = UTX_START;
        end
      end
      UTX_START: begin
        tx_d = UART_START_BIT;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = UTX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UTX_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UTX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UTX_STOP: begin
        tx_d = UART_STOP_BIT;
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame to avoid an idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = UTX_START;
          end else begin
            state_d = UTX_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = UTX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_utx_gck) begin
    if (i_utx_rst) begin
      phase_q  <= 1'b0;
      nib_lo_q <= '0;
      ovf_q    <= 1'b0;
      state_q  <= UTX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= UART_STOP_BIT;
    end else begin
      phase_q  <= phase_d;
      nib_lo_q <= nib_lo_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign o_utx_rdy  = fifo_rdy;
  assign o_utx_ovf  = ovf_q;
  assign o_utx_idle = fifo_empty & (state_q == UTX_IDLE) & ~phase_q;
  assign o_utx_tx   = tx_q;

endmodule

// File: tb/tb_idli_uart_tx_m.sv
module tb_idli_uart_tx_m;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld_a, vld_b;
  logic [3:0] data_a, data_b;
  logic       rdy_a, ovf_a, idle_a, tx_a;
  logic       rdy_b, ovf_b, idle_b, tx_b;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  logic log_a [0:4095];
  logic log_b [0:4095];

  always #5 clk = ~clk;

  idli_uart_tx_m #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
    .i_utx_gck  (clk),
    .i_utx_rst  (rst),
    .i_utx_vld  (vld_a),
    .i_utx_data (data_a),
    .o_utx_rdy  (rdy_a),
    .o_utx_ovf  (ovf_a),
    .o_utx_idle (idle_a),
    .o_utx_tx   (tx_a)
  );

  idli_uart_tx_m #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut_b (
    .i_utx_gck  (clk),
    .i_utx_rst  (rst),
    .i_utx_vld  (vld_b),
    .i_utx_data (data_b),
    .o_utx_rdy  (rdy_b),
    .o_utx_ovf  (ovf_b),
    .o_utx_idle (idle_b),
    .o_utx_tx   (tx_b)
  );

  // Line recorder: one sample per cycle, taken mid-cycle. Index c holds the
  // level seen just after the c-th rising edge counted by ncyc.
  always @(negedge clk) begin
    if (ncyc < 4096) begin
      log_a[ncyc] = tx_a;
      log_b[ncyc] = tx_b;
    end
    ncyc = ncyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (ncyc < c) tick();
  endtask

  // Present one byte as two consecutive nibbles; returns just after the
  // edge that samples the high nibble.
  task automatic send(input bit sel_b, input logic [7:0] b);
    if (sel_b) begin vld_b = 1'b1; data_b = b[3:0]; end
    else       begin vld_a = 1'b1; data_a = b[3:0]; end
    tick();
    if (sel_b) data_b = b[7:4];
    else       data_a = b[7:4];
    tick();
    vld_a = 1'b0; data_a = 4'h0;
    vld_b = 1'b0; data_b = 4'h0;
  endtask

  // Expected line level k cycles into an 8N1 frame of byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int cpb, input int k);
    int p;
    p = k / cpb;
    if (p == 0) return 1'b0;
    if (p >= 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic test_reset();
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; data_a = 4'h0; data_b = 4'h0;
    tick(); tick();
    n_checks++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL reset_tx got %b expected 1", tx_a); end
    n_checks++; if (ovf_a !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b expected 0", ovf_a); end
    n_checks++; if (rdy_a !== 1'b1)  begin n_fail++; $display("FAIL reset_rdy got %b expected 1", rdy_a); end
    n_checks++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b expected 1", idle_a); end
    n_checks++; if (tx_b !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_b got %b expected 1", tx_b); end
    n_checks++; if (idle_b !== 1'b1) begin n_fail++; $display("FAIL reset_idle_b got %b expected 1", idle_b); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    int c0;
    send(1'b0, 8'hA5);
    c0 = ncyc;
    n_checks++; if (idle_a !== 1'b0) begin n_fail++; $display("FAIL single_busy idle got %b expected 0", idle_a); end
    wait_to(c0 + 43);
    n_checks++; if (log_a[c0+1] !== 1'b1) begin n_fail++; $display("FAIL single_latency tx got %b expected 1", log_a[c0+1]); end
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (log_a[c0+2+k] !== exp_bit(8'hA5, 4, k)) begin
        n_fail++; $display("FAIL single_frame[%0d] tx got %b expected %b", k, log_a[c0+2+k], exp_bit(8'hA5, 4, k));
      end
    end
    n_checks++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL single_idle got %b expected 1", idle_a); end
    n_checks++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL single_tx_end got %b expected 1", tx_a); end
    $display("test_single_byte done: byte 0xa5");
  endtask

  task automatic test_nibble_gap();
    int cs, c0;
    vld_a = 1'b1; data_a = 4'h3;
    tick();
    vld_a = 1'b0; data_a = 4'h0;
    cs = ncyc;
    repeat (7) tick();
    n_checks++; if (idle_a !== 1'b0) begin n_fail++; $display("FAIL gap_pending idle got %b expected 0", idle_a); end
    vld_a = 1'b1; data_a = 4'h4;
    tick();
    vld_a = 1'b0; data_a = 4'h0;
    c0 = ncyc;
    wait_to(c0 + 50);
    for (int c = cs; c < c0 + 2; c++) begin
      n_checks++;
      if (log_a[c] !== 1'b1) begin n_fail++; $display("FAIL gap_early cycle %0d tx got %b expected 1", c - cs, log_a[c]); end
    end
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (log_a[c0+2+k] !== exp_bit(8'h43, 4, k)) begin
        n_fail++; $display("FAIL gap_frame[%0d] tx got %b expected %b", k, log_a[c0+2+k], exp_bit(8'h43, 4, k));
      end
    end
    for (int k = 42; k < 50; k++) begin
      n_checks++;
      if (log_a[c0+k] !== 1'b1) begin n_fail++; $display("FAIL gap_after[%0d] tx got %b expected 1", k, log_a[c0+k]); end
    end
    $display("test_nibble_gap done: byte 0x43");
  endtask

  task automatic test_overflow();
    int c0;
    logic [7:0] b;
    send(1'b0, 8'h01);
    c0 = ncyc;
    for (int i = 2; i <= 5; i++) send(1'b0, 8'(i));
    n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL ovf_full_rdy got %b expected 0", rdy_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b expected 0", ovf_a); end
    send(1'b0, 8'h06);
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b expected 1", ovf_a); end
    n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy got %b expected 0", rdy_a); end
    wait_to(c0 + 2 + 200 + 8);
    for (int k = 0; k < 200; k++) begin
      b = 8'(1 + k / 40);
      n_checks++;
      if (log_a[c0+2+k] !== exp_bit(b, 4, k % 40)) begin
        n_fail++; $display("FAIL ovf_frames[%0d] tx got %b expected %b", k, log_a[c0+2+k], exp_bit(b, 4, k % 40));
      end
    end
    for (int k = 200; k < 208; k++) begin
      n_checks++;
      if (log_a[c0+2+k] !== 1'b1) begin n_fail++; $display("FAIL ovf_no_sixth[%0d] tx got %b expected 1", k, log_a[c0+2+k]); end
    end
    n_checks++; if (ovf_a !== 1'b1)  begin n_fail++; $display("FAIL ovf_sticky got %b expected 1", ovf_a); end
    n_checks++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL ovf_idle got %b expected 1", idle_a); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (ovf_a !== 1'b0)  begin n_fail++; $display("FAIL ovf_clear got %b expected 0", ovf_a); end
    tick();
    $display("test_overflow done: bytes 0x01..0x05 sent, 0x06 dropped");
  endtask

  task automatic test_full_pop();
    int c0;
    logic [7:0] b;
    logic [7:0] seq [6];
    seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send(1'b0, 8'h11);
    c0 = ncyc;
    for (int i = 1; i < 5; i++) send(1'b0, seq[i]);
    n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL fp_full rdy got %b expected 0", rdy_a); end
    wait_to(c0 + 19);
    vld_a = 1'b1; data_a = 4'h6;
    tick();
    vld_a = 1'b0; data_a = 4'h0;
    // Edge c0+41 is the last STOP cycle of frame 1, where the FIFO pops.
    wait_to(c0 + 40);
    vld_a = 1'b1; data_a = 4'h1;
    tick();
    vld_a = 1'b0; data_a = 4'h0;
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL fp_ovf got %b expected 0", ovf_a); end
    n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL fp_still_full rdy got %b expected 0", rdy_a); end
    wait_to(c0 + 2 + 240 + 4);
    for (int k = 0; k < 240; k++) begin
      b = seq[k / 40];
      n_checks++;
      if (log_a[c0+2+k] !== exp_bit(b, 4, k % 40)) begin
        n_fail++; $display("FAIL fp_frames[%0d] tx got %b expected %b", k, log_a[c0+2+k], exp_bit(b, 4, k % 40));
      end
    end
    n_checks++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL fp_idle got %b expected 1", idle_a); end
    $display("test_full_pop done: byte 0x16 accepted on pop cycle");
  endtask

  task automatic test_reset_mid_frame();
    int c0, c1;
    send(1'b0, 8'hFF);
    c0 = ncyc;
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    // Data bit 3 of the first frame occupies cycles c0+18..c0+21.
    wait_to(c0 + 19);
    n_checks++; if (idle_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy idle got %b expected 0", idle_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL rst_tx got %b expected 1", tx_a); end
    n_checks++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b expected 1", idle_a); end
    n_checks++; if (rdy_a !== 1'b1)  begin n_fail++; $display("FAIL rst_rdy got %b expected 1", rdy_a); end
    wait_to(c0 + 80);
    for (int c = c0 + 20; c < c0 + 80; c++) begin
      n_checks++;
      if (log_a[c] !== 1'b1) begin n_fail++; $display("FAIL rst_quiet cycle %0d tx got %b expected 1", c - c0, log_a[c]); end
    end
    send(1'b0, 8'hC0);
    c1 = ncyc;
    wait_to(c1 + 44);
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (log_a[c1+2+k] !== exp_bit(8'hC0, 4, k)) begin
        n_fail++; $display("FAIL rst_after_frame[%0d] tx got %b expected %b", k, log_a[c1+2+k], exp_bit(8'hC0, 4, k));
      end
    end
    n_checks++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL rst_after_idle got %b expected 1", idle_a); end
    $display("test_reset_mid_frame done: frame aborted, byte 0xc0 sent after");
  endtask

  task automatic test_cpb2();
    int c0;
    send(1'b1, 8'h80);
    c0 = ncyc;
    wait_to(c0 + 25);
    n_checks++; if (log_b[c0+1] !== 1'b1) begin n_fail++; $display("FAIL cpb2_latency tx got %b expected 1", log_b[c0+1]); end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (log_b[c0+2+k] !== exp_bit(8'h80, 2, k)) begin
        n_fail++; $display("FAIL cpb2_frame[%0d] tx got %b expected %b", k, log_b[c0+2+k], exp_bit(8'h80, 2, k));
      end
    end
    n_checks++; if (log_b[c0+22] !== 1'b1) begin n_fail++; $display("FAIL cpb2_after tx got %b expected 1", log_b[c0+22]); end
    n_checks++; if (idle_b !== 1'b1)       begin n_fail++; $display("FAIL cpb2_idle got %b expected 1", idle_b); end
    $display("test_cpb2 done: byte 0x80 at 2 clocks per bit");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_nibble_gap();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_cpb2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

endmodule
